// File: rtl/fb_pkg.sv
// Shared types for the framebuffer scan-out slice.
//
// pixel_t      : 9-bit RGB333 pixel, packed as {r, g, b}.
// scan_state_t : scan-out sequencer states (IDLE, FETCH, DRAIN).
// test_pattern : builds the debug pattern pixel {x[2:0], y[2:0], x[5:3]}
//                from raster coordinates.
package fb_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } scan_state_t;

  function automatic pixel_t test_pattern(input logic [5:0] x, input logic [2:0] y);
    return pixel_t'({x[2:0], y, x[5:3]});
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// Synchronous pixel FIFO with a show-ahead head.
//
// Ports:
//   clock      : clock
//   reset      : synchronous active-high reset, empties the FIFO
//   flush      : synchronous empty request, has priority over push/pop
//   push       : write push_data this cycle (caller guarantees space)
//   push_data  : element to write
//   pop        : retire the head element (ignored when empty)
//   head       : oldest element, read straight from storage
//   count      : number of stored elements, 0..DEPTH
//   empty/full : count == 0 / count == DEPTH
//
// DEPTH must be a power of two so the pointers wrap naturally. A pushed
// element is visible at head one cycle later; there is no bypass path.
module fb_fifo
  import fb_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type elem_t = pixel_t,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  elem_t            push_data,
  input  logic             pop,
  output elem_t            head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  // NOTE: storage is reset on purpose; head is read directly from it, so
  // this is what makes the pixel output read zero coming out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop in
  // the design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: walks the frame in raster order on RAM port B,
// absorbs the RAM read latency and streams pixels to the VGA block.
//
// Ports:
//   clock       : VGA pixel clock
//   reset       : synchronous active-high reset
//   frame_start : 1-cycle pulse at vertical sync; starts (or restarts) a frame
//   address     : RAM port B word address
//   q           : RAM port B read data, valid RAM_LATENCY cycles after address
//   pix_valid   : pix_data holds a pixel
//   pix_data    : pixel to VGA, {R[2:0],G[2:0],B[2:0]}
//   pix_ready   : VGA consumes pix_data this cycle
//   frame_done  : 1-cycle pulse after the last pixel of the frame is popped
//   underflow   : sticky; VGA asked for a pixel that was not there
//   test_mode   : selects the test pattern (only with FB_SCANOUT_TESTPAT_EN)
//
// Build option: define FB_SCANOUT_TESTPAT_EN to enable the coordinate test
// pattern; without it test_mode is ignored and push data is always q.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int                WIDTH       = 128,
  parameter int                HEIGHT      = 3,
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RAM_LATENCY = 2,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] q,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              underflow,
  input  logic              test_mode
);

  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int IDX_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

  scan_state_t            state;
  logic [IDX_W-1:0]       pix_idx;
  logic [RAM_LATENCY-1:0] pipe_vld;    // one bit per read in flight
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   unused_fifo_full;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   last_pop;
  pixel_t                 push_data;
  pixel_t                 fifo_head;

  // NOTE: combinational blocks assign a default first so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + CNT_W'(pipe_vld[i]);
  end

  // Credit check: every issued read already owns a FIFO slot, so pushes can
  // never exceed the free space and no overflow handling is needed.
  assign issue = (state == FETCH) &&
                 ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight) < (CNT_W+1)'(FIFO_DEPTH));

  assign push      = pipe_vld[RAM_LATENCY-1];
  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = fifo_head;

  // In DRAIN every read has been issued, so the frame ends when the only
  // stored pixel leaves and nothing is left in the latency pipe.
  assign last_pop = (state == DRAIN) && pop &&
                    (fifo_count == CNT_W'(1)) && (inflight == '0);

`ifdef FB_SCANOUT_TESTPAT_EN
  localparam int XW = ($clog2(WIDTH)  > 6) ? $clog2(WIDTH)  : 6;
  localparam int YW = ($clog2(HEIGHT) > 3) ? $clog2(HEIGHT) : 3;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  pixel_t        pat_pipe [RAM_LATENCY];

  // The pattern travels alongside the read so it lands with the right pixel.
  always_ff @(posedge clock) begin
    pat_pipe[0] <= test_pattern(x_cnt[5:0], y_cnt[2:0]);
    for (int i = 1; i < RAM_LATENCY; i++) pat_pipe[i] <= pat_pipe[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset || frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (issue) begin
      if (x_cnt == XW'(WIDTH - 1)) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  assign push_data = test_mode ? pat_pipe[RAM_LATENCY-1] : pixel_t'(q);
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign push_data        = pixel_t'(q);
`endif

  fb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (pixel_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (frame_start),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (unused_fifo_full)
  );

  // Sequencer. frame_start outranks everything: it aborts any frame in
  // progress, drops reads in flight and suppresses frame_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      address    <= BASE_ADDR;
      pix_idx    <= '0;
      pipe_vld   <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      state      <= FETCH;
      address    <= BASE_ADDR;
      pix_idx    <= '0;
      pipe_vld   <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pipe_vld   <= (pipe_vld << 1) | RAM_LATENCY'(issue);
      if (pix_ready && !pix_valid && state != IDLE) underflow <= 1'b1;
      case (state)
        IDLE: begin
        end
        FETCH: begin
          if (issue) begin
            if (pix_idx == IDX_W'(FRAME_PIXELS - 1)) begin
              state <= DRAIN;
            end else begin
              pix_idx <= pix_idx + IDX_W'(1);
              address <= address + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            end
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            address    <= BASE_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a behavioural RAM feeds two instances (default
// geometry, and a small frame placed to wrap the address space). Expected
// pixels are queued when a frame is started and checked by a monitor.
module tb_fb_scanout;

  localparam int          WIDTH   = 128;
  localparam int          HEIGHT  = 3;
  localparam int          FRAME   = WIDTH * HEIGHT;
  localparam int          W_WIDTH = 32;
  localparam logic [15:0] W_BASE  = 16'hFFF0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, frame_start, pix_ready, test_mode;
  logic [15:0] address;
  logic [8:0]  q, pix_data;
  logic        pix_valid, frame_done, underflow;

  logic        fs_w, ready_w;
  logic [15:0] address_w;
  logic [8:0]  q_w, pix_data_w;
  logic        pix_valid_w, frame_done_w, underflow_w;

  logic [8:0]  ram [0:65535];
  logic [15:0] a_r, a_r_w;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q [$];
  logic [8:0] exp_w [$];
  int         done_cnt   = 0;
  int         done_w     = 0;
  int         frame_pops = 0;
  bit         wrapped    = 1'b0;
  logic [15:0] prev_addr_w = 16'h0;

  fb_scanout dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .address(address),
    .q(q), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .frame_done(frame_done), .underflow(underflow), .test_mode(test_mode)
  );

  fb_scanout #(.WIDTH(W_WIDTH), .HEIGHT(1), .BASE_ADDR(W_BASE)) dut_w (
    .clock(clock), .reset(reset), .frame_start(fs_w), .address(address_w),
    .q(q_w), .pix_valid(pix_valid_w), .pix_data(pix_data_w), .pix_ready(ready_w),
    .frame_done(frame_done_w), .underflow(underflow_w), .test_mode(test_mode)
  );

  // Two-cycle RAM: registered address, registered data.
  always @(posedge clock) begin
    a_r   <= address;
    q     <= ram[a_r];
    a_r_w <= address_w;
    q_w   <= ram[a_r_w];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [8:0] pattern_of(input int idx);
    int x;
    int y;
    x = idx % WIDTH;
    y = idx / WIDTH;
    return {x[2:0], y[2:0], x[5:3]};
  endfunction

  function automatic logic [8:0] exp_pixel(input int idx, input bit tm);
    if (tm) return pattern_of(idx);
    return ram[idx[15:0]];
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; frame_start is sampled at the next one.
  task automatic start_frame(input bit tm);
    exp_q.delete();
    for (int i = 0; i < FRAME; i++) exp_q.push_back(exp_pixel(i, tm));
    frame_pops  = 0;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!pix_valid && n < 50) begin cycle(); n++; end
    check("wait_pix_valid", 32'(pix_valid), 1);
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    check("drain_in_budget", 32'(exp_q.size()), 0);
    pix_ready = 1'b1;
    repeat (3) cycle();
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready && !frame_start) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
          frame_pops++;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done_w) done_w++;
      if (pix_valid_w && ready_w && !fs_w) begin
        check("w_has_entry", 32'(exp_w.size() > 0), 1);
        if (exp_w.size() > 0) check("w_pix_data", 32'(pix_data_w), 32'(exp_w.pop_front()));
      end
      if (prev_addr_w == 16'hFFFF && address_w == 16'h0000) wrapped = 1'b1;
      prev_addr_w = address_w;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int d0;
    int abort_at;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) ram[i] = 9'($urandom);
    reset = 1'b1; frame_start = 1'b0; pix_ready = 1'b0; test_mode = 1'b0;
    fs_w = 1'b0; ready_w = 1'b0;
    repeat (3) cycle();

    // Reset values.
    check("rst_address", 32'(address), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_address_w", 32'(address_w), 32'(W_BASE));
    reset = 1'b0;
    repeat (2) cycle();

    // Full frame, no backpressure once data arrives; first-pixel latency.
    d0 = done_cnt;
    start_frame(1'b0);
    k = 1;
    while (!pix_valid && k < 20) begin cycle(); k++; end
    check("first_valid_latency", 32'(k), 4);
    pix_ready = 1'b1;
    wait_drain(2000, 1'b0);
    check("t1_frame_done_once", 32'(done_cnt - d0), 1);
    check("t1_underflow", 32'(underflow), 0);
    repeat (10) cycle();
    check("t1_idle_ignores_ready", 32'(underflow), 0);
    check("t1_idle_no_valid", 32'(pix_valid), 0);

    // Backpressure: FIFO fills, issuing stops, stream resumes intact.
    pix_ready = 1'b0;
    d0 = done_cnt;
    start_frame(1'b0);
    repeat (20) cycle();
    check("t2_valid_held", 32'(pix_valid), 1);
    check("t2_addr_stalled", 32'(address), 8);
    repeat (5) cycle();
    check("t2_addr_still_stalled", 32'(address), 8);
    pix_ready = 1'b1;
    wait_drain(2000, 1'b0);
    check("t2_frame_done_once", 32'(done_cnt - d0), 1);
    check("t2_underflow", 32'(underflow), 0);

    // Early ready: underflow sets before data, stays sticky, frame_start clears.
    d0 = done_cnt;
    start_frame(1'b0);
    cycle();
    check("t3_underflow_set", 32'(underflow), 1);
    check("t3_no_valid_yet", 32'(pix_valid), 0);
    wait_drain(2000, 1'b0);
    check("t3_underflow_sticky", 32'(underflow), 1);
    check("t3_frame_done_once", 32'(done_cnt - d0), 1);
    pix_ready = 1'b0;
    start_frame(1'b0);
    check("t3_underflow_cleared", 32'(underflow), 0);

    // Abort at pixel 100: restart from pixel 0, no done for the aborted frame.
    wait_valid();
    pix_ready = 1'b1;
    n = 0;
    while (frame_pops < 100 && n < 2000) begin cycle(); n++; end
    check("t4_reached_100", 32'(frame_pops >= 100), 1);
    d0 = done_cnt;
    start_frame(1'b0);
    repeat (3) cycle();
    check("t4_no_done_on_abort", 32'(done_cnt - d0), 0);
    wait_drain(2000, 1'b0);
    check("t4_done_for_restart", 32'(done_cnt - d0), 1);

    // frame_start in the same cycle as the final pop: abort wins.
    start_frame(1'b0);
    n = 0;
    while (!(exp_q.size() == 1 && pix_valid) && n < 2000) begin cycle(); n++; end
    check("t4b_at_last_pixel", 32'(exp_q.size()), 1);
    d0 = done_cnt;
    start_frame(1'b0);
    repeat (3) cycle();
    check("t4b_no_done", 32'(done_cnt - d0), 0);
    wait_drain(2000, 1'b0);
    check("t4b_done_for_restart", 32'(done_cnt - d0), 1);

    // Random backpressure, abort at a random point, then a random full frame.
    start_frame(1'b0);
    abort_at = $urandom_range(20, 360);
    n = 0;
    while (frame_pops < abort_at && n < 5000) begin
      pix_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    check("rnd_abort_reached", 32'(frame_pops >= abort_at), 1);
    d0 = done_cnt;
    start_frame(1'b0);
    wait_drain(5000, 1'b1);
    check("rnd_done_once", 32'(done_cnt - d0), 1);

`ifdef FB_SCANOUT_TESTPAT_EN
    // Test pattern replaces RAM data; pixel (9,2) must read 9'b001_010_001.
    test_mode = 1'b1;
    pix_ready = 1'b0;
    d0 = done_cnt;
    start_frame(1'b1);
    wait_valid();
    pix_ready = 1'b1;
    wait_drain(2000, 1'b0);
    check("t6_done_once", 32'(done_cnt - d0), 1);
    test_mode = 1'b0;
`endif

    // Address wrap on the second instance: FFF0..FFFF, 0000..000F.
    exp_w.delete();
    for (int i = 0; i < W_WIDTH; i++) begin
      a = W_BASE + 16'(i);
      exp_w.push_back(ram[a]);
    end
    fs_w = 1'b1;
    cycle();
    fs_w    = 1'b0;
    ready_w = 1'b1;
    n = 0;
    while (exp_w.size() != 0 && n < 500) begin cycle(); n++; end
    check("t5_drained", 32'(exp_w.size()), 0);
    repeat (3) cycle();
    check("t5_frame_done_once", 32'(done_w), 1);
    check("t5_address_wrapped", 32'(wrapped), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
